// File: rtl/plic_pkg.sv
// Shared PLIC types: target-context FSM encoding and the reserved "no interrupt" ID.
package plic_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CLAIMED = 1'b1
  } plic_state_e;

  localparam int unsigned PLIC_NO_ID = 0;

endpackage : plic_pkg

// File: rtl/plic_prio_tree.sv
// Combinational arbiter: highest-priority eligible source, ties to the lowest ID.
module plic_prio_tree
  import plic_pkg::*;
#(
  parameter int unsigned NUM_SRC = 15,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic [NUM_SRC-1:0]        pending_i,
  input  logic [NUM_SRC-1:0]        enable_i,
  input  logic [NUM_SRC-1:0]        inflight_i,
  input  logic [NUM_SRC*PRIO_W-1:0] priority_i,
  output logic [ID_W-1:0]           best_id_o,
  output logic [PRIO_W-1:0]         best_prio_o
);

  logic [NUM_SRC-1:0] cand_c;

  assign cand_c = pending_i & enable_i & ~inflight_i;

  // Ascending scan with strict '>' keeps the lowest ID on ties and skips priority 0.
  always_comb begin
    best_id_o   = ID_W'(PLIC_NO_ID);
    best_prio_o = '0;
    for (int n = 1; n <= int'(NUM_SRC); n++) begin
      if (cand_c[n-1] && (priority_i[(n-1)*int'(PRIO_W) +: PRIO_W] > best_prio_o)) begin
        best_id_o   = ID_W'(n);
        best_prio_o = priority_i[(n-1)*int'(PRIO_W) +: PRIO_W];
      end
    end
  end

endmodule : plic_prio_tree

// File: rtl/plic_target_ctx.sv
// PLIC per-target context: registered arbitration, threshold gating and claim/complete handshake.
module plic_target_ctx
  import plic_pkg::*;
#(
  parameter int unsigned NUM_SRC = 15,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        pending_i,
  input  logic [NUM_SRC-1:0]        enable_i,
  input  logic [NUM_SRC*PRIO_W-1:0] priority_i,
  input  logic [PRIO_W-1:0]         threshold_i,
  input  logic                      claim_i,
  input  logic                      complete_i,
  input  logic [ID_W-1:0]           complete_id_i,
  output logic                      ireq_o,
  output logic [ID_W-1:0]           id_o,
  output logic [ID_W-1:0]           claim_id_o,
  output logic [NUM_SRC-1:0]        claimed_o,
  output logic                      busy_o
);

  plic_state_e        state_q;
  logic [ID_W-1:0]    id_q, id_d;
  logic [PRIO_W-1:0]  best_prio_q, best_prio_d;
  logic               ireq_q;
  logic [ID_W-1:0]    claim_id_q;
  logic [NUM_SRC-1:0] claimed_q;
  logic [NUM_SRC-1:0] inflight_q;
  logic               busy_q;
  logic [NUM_SRC-1:0] id_onehot_c;
  logic               prio_above_c;

  plic_prio_tree #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W),
    .PRIO_W  (PRIO_W)
  ) u_prio_tree (
    .pending_i   (pending_i),
    .enable_i    (enable_i),
    .inflight_i  (inflight_q),
    .priority_i  (priority_i),
    .best_id_o   (id_d),
    .best_prio_o (best_prio_d)
  );

  // One-hot of the registered best ID; all-zero when the ID is 0.
  always_comb begin
    id_onehot_c = '0;
    for (int n = 1; n <= int'(NUM_SRC); n++) begin
      id_onehot_c[n-1] = (id_q == ID_W'(n));
    end
  end

  assign prio_above_c = (best_prio_q > threshold_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      id_q        <= ID_W'(PLIC_NO_ID);
      best_prio_q <= '0;
      ireq_q      <= 1'b0;
      claim_id_q  <= ID_W'(PLIC_NO_ID);
      claimed_q   <= '0;
      inflight_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      id_q        <= id_d;
      best_prio_q <= best_prio_d;
      claimed_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          ireq_q <= prio_above_c;
          if (claim_i) begin
            if (ireq_q && (id_q != ID_W'(PLIC_NO_ID))) begin
              claim_id_q <= id_q;
              claimed_q  <= id_onehot_c;
              inflight_q <= id_onehot_c;
              state_q    <= ST_CLAIMED;
              busy_q     <= 1'b1;
              ireq_q     <= 1'b0;
            end else begin
              claim_id_q <= ID_W'(PLIC_NO_ID);
            end
          end
        end
        ST_CLAIMED: begin
          ireq_q <= 1'b0;
          if (claim_i) begin
            claim_id_q <= ID_W'(PLIC_NO_ID);
          end
          // Only the completion of the claimed ID releases the context.
          if (complete_i && (complete_id_i == claim_id_q)) begin
            inflight_q <= '0;
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            ireq_q     <= prio_above_c;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ireq_o     = ireq_q;
  assign id_o       = id_q;
  assign claim_id_o = claim_id_q;
  assign claimed_o  = claimed_q;
  assign busy_o     = busy_q;

endmodule : plic_target_ctx

// File: tb/tb_plic_target_ctx.sv
// Directed bench for plic_target_ctx with hand-computed expectations.
module tb_plic_target_ctx;

  localparam int unsigned NUM_SRC = 15;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned PRIO_W  = 3;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_SRC-1:0]        pending_i;
  logic [NUM_SRC-1:0]        enable_i;
  logic [NUM_SRC*PRIO_W-1:0] priority_i;
  logic [PRIO_W-1:0]         threshold_i;
  logic                      claim_i;
  logic                      complete_i;
  logic [ID_W-1:0]           complete_id_i;
  logic                      ireq_o;
  logic [ID_W-1:0]           id_o;
  logic [ID_W-1:0]           claim_id_o;
  logic [NUM_SRC-1:0]        claimed_o;
  logic                      busy_o;

  int n_cmp;
  int n_bad;

  plic_target_ctx #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W),
    .PRIO_W  (PRIO_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pending_i     (pending_i),
    .enable_i      (enable_i),
    .priority_i    (priority_i),
    .threshold_i   (threshold_i),
    .claim_i       (claim_i),
    .complete_i    (complete_i),
    .complete_id_i (complete_id_i),
    .ireq_o        (ireq_o),
    .id_o          (id_o),
    .claim_id_o    (claim_id_o),
    .claimed_o     (claimed_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_prio(input int src, input logic [PRIO_W-1:0] p);
    priority_i[(src-1)*int'(PRIO_W) +: PRIO_W] = p;
  endtask

  function automatic logic [NUM_SRC-1:0] bit_of(input int src);
    logic [NUM_SRC-1:0] m;
    m = '0;
    m[src-1] = 1'b1;
    return m;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    pending_i = '0;
    enable_i = '0;
    priority_i = '0;
    threshold_i = '0;
    claim_i = 1'b0;
    complete_i = 1'b0;
    complete_id_i = '0;

    // Reset state
    tick(2);
    chk("rst_ireq", 64'(ireq_o), 64'd0);
    chk("rst_id", 64'(id_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_claimed", 64'(claimed_o), 64'd0);
    #2 rst_n = 1'b1;
    tick(1);

    // Tie at priority 5 between sources 3 and 7: lowest ID wins
    enable_i = '1;
    set_prio(3, 3'd5);
    set_prio(7, 3'd5);
    pending_i = bit_of(3) | bit_of(7);
    threshold_i = 3'd2;
    tick(1);
    chk("tie_id_1cyc", 64'(id_o), 64'd3);
    chk("tie_ireq_1cyc", 64'(ireq_o), 64'd0);
    tick(1);
    chk("tie_ireq_2cyc", 64'(ireq_o), 64'd1);

    // Priority equal to threshold does not interrupt; lowering threshold does
    set_prio(3, 3'd0);
    set_prio(7, 3'd0);
    set_prio(4, 3'd2);
    pending_i = bit_of(4);
    tick(3);
    chk("thr_eq_id", 64'(id_o), 64'd4);
    chk("thr_eq_ireq", 64'(ireq_o), 64'd0);
    threshold_i = 3'd1;
    tick(1);
    chk("thr_lower_ireq", 64'(ireq_o), 64'd1);

    // Claim source 4 with source 7 (prio 1) also waiting
    set_prio(7, 3'd1);
    threshold_i = 3'd0;
    pending_i = bit_of(4) | bit_of(7);
    tick(2);
    chk("pre_claim_id", 64'(id_o), 64'd4);
    chk("pre_claim_ireq", 64'(ireq_o), 64'd1);
    claim_i = 1'b1;
    tick(1);
    claim_i = 1'b0;
    chk("claim_id", 64'(claim_id_o), 64'd4);
    chk("claim_pulse", 64'(claimed_o), 64'h0008);
    chk("claim_busy", 64'(busy_o), 64'd1);
    chk("claim_ireq", 64'(ireq_o), 64'd0);
    tick(1);
    chk("pulse_1cyc", 64'(claimed_o), 64'd0);
    chk("inflight_masked_id", 64'(id_o), 64'd7);
    chk("claimed_ireq_low", 64'(ireq_o), 64'd0);
    complete_i = 1'b1;
    complete_id_i = 4'd5;
    tick(1);
    complete_i = 1'b0;
    chk("wrong_cmpl_busy", 64'(busy_o), 64'd1);
    pending_i = bit_of(7);
    complete_i = 1'b1;
    complete_id_i = 4'd4;
    tick(1);
    complete_i = 1'b0;
    chk("cmpl_busy", 64'(busy_o), 64'd0);
    chk("cmpl_ireq_again", 64'(ireq_o), 64'd1);
    chk("cmpl_id", 64'(id_o), 64'd7);

    // Claim while no request is raised returns ID 0
    enable_i = '0;
    tick(2);
    chk("noreq_ireq", 64'(ireq_o), 64'd0);
    claim_i = 1'b1;
    tick(1);
    claim_i = 1'b0;
    chk("noreq_claim_id", 64'(claim_id_o), 64'd0);
    chk("noreq_pulse", 64'(claimed_o), 64'd0);
    chk("noreq_busy", 64'(busy_o), 64'd0);

    // Completion in IDLE is ignored
    complete_i = 1'b1;
    complete_id_i = 4'd7;
    tick(1);
    complete_i = 1'b0;
    chk("idle_cmpl_busy", 64'(busy_o), 64'd0);

    // Claim and matching completion in the same cycle
    enable_i = '1;
    tick(2);
    chk("s7_ireq", 64'(ireq_o), 64'd1);
    claim_i = 1'b1;
    tick(1);
    claim_i = 1'b0;
    chk("s7_claim_id", 64'(claim_id_o), 64'd7);
    chk("s7_pulse", 64'(claimed_o), 64'h0040);
    claim_i = 1'b1;
    complete_i = 1'b1;
    complete_id_i = 4'd7;
    tick(1);
    claim_i = 1'b0;
    complete_i = 1'b0;
    chk("both_busy", 64'(busy_o), 64'd0);
    chk("both_claim_id", 64'(claim_id_o), 64'd0);

    // Reset mid-claim abandons the claim
    tick(3);
    chk("re_ireq", 64'(ireq_o), 64'd1);
    claim_i = 1'b1;
    tick(1);
    claim_i = 1'b0;
    chk("re_busy", 64'(busy_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_claim_id", 64'(claim_id_o), 64'd0);
    chk("arst_id", 64'(id_o), 64'd0);
    chk("arst_ireq", 64'(ireq_o), 64'd0);
    tick(1);
    #2 rst_n = 1'b1;
    tick(2);
    chk("post_rst_ireq", 64'(ireq_o), 64'd1);
    chk("post_rst_id", 64'(id_o), 64'd7);
    claim_i = 1'b1;
    tick(1);
    claim_i = 1'b0;
    chk("post_rst_claim_id", 64'(claim_id_o), 64'd7);
    chk("post_rst_pulse", 64'(claimed_o), 64'h0040);
    chk("post_rst_busy", 64'(busy_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_plic_target_ctx
